// File: rtl/imx_frame_pattern_gen_pkg.sv
// Shared encodings for the IMX frame pattern generator: FSM states, payload modes,
// sync-code length and the row-entry helper.
package imx_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VBLANK  = 3'd1,
    ST_HBLANK  = 3'd2,
    ST_DELAY   = 3'd3,
    ST_SYNC    = 3'd4,
    ST_PAYLOAD = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_INC  = 2'd1,
    MODE_LANE = 2'd2,
    MODE_WALK = 2'd3
  } mode_e;

  localparam int SYNC_LEN = 4;

  // First state of a row: zero-length blanking/delay phases are skipped entirely.
  function automatic state_e row_entry(input logic hblankNz, input logic delayNz);
    if (hblankNz)     return ST_HBLANK;
    else if (delayNz) return ST_DELAY;
    else              return ST_SYNC;
  endfunction

endpackage

// File: rtl/imx_frame_pattern_gen_if.sv
// Bundle of the generator's control, timing-config and video-output signals.
interface imx_frame_pattern_gen_if #(
  parameter int LANE_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                    enable;
  logic [1:0]              mode;
  logic [CNT_WIDTH-1:0]    vblank;
  logic [CNT_WIDTH-1:0]    rows;
  logic [CNT_WIDTH-1:0]    hblank;
  logic [CNT_WIDTH-1:0]    start_delay;
  logic [CNT_WIDTH-1:0]    row_words;
  logic                    vs;
  logic                    hs;
  logic [8*LANE_WIDTH-1:0] data;
  logic                    data_valid;
  logic [31:0]             frame_count;
  logic                    busy;

  modport master (
    input  enable, mode, vblank, rows, hblank, start_delay, row_words,
    output vs, hs, data, data_valid, frame_count, busy
  );

  modport slave (
    output enable, mode, vblank, rows, hblank, start_delay, row_words,
    input  vs, hs, data, data_valid, frame_count, busy
  );
endinterface

// File: rtl/imx_frame_pattern_gen_lane.sv
// One payload byte lane: derives the byte for word index word_i on lane LANE_IDX.
module imx_lane_pattern
  import imx_pattern_pkg::*;
#(
  parameter int LANE_IDX = 0
) (
  input  mode_e       mode_i,
  input  logic [7:0]  word_i,
  output logic [7:0]  byte_o
);
  localparam logic [7:0] LaneByte = LANE_IDX[7:0];

  logic [7:0] sum;

  always_comb begin
    sum = word_i + LaneByte;
    case (mode_i)
      MODE_ZERO: byte_o = 8'h00;
      MODE_INC:  byte_o = sum;
      MODE_LANE: byte_o = LaneByte;
      default:   byte_o = 8'h01 << sum[2:0];
    endcase
  end
endmodule

// File: rtl/imx_frame_pattern_gen.sv
// Frame/row timing generator: VS/HS framing, 4-byte row sync code and a selectable
// test payload on LANE_WIDTH byte lanes, plus a completed-frame counter.
module imx_frame_pattern_gen
  import imx_pattern_pkg::*;
#(
  parameter int          LANE_WIDTH = 8,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] SYNC_CODE  = 32'h7F80_0040
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic [1:0]              i_mode,
  input  logic [CNT_WIDTH-1:0]    i_vblank,
  input  logic [CNT_WIDTH-1:0]    i_rows,
  input  logic [CNT_WIDTH-1:0]    i_hblank,
  input  logic [CNT_WIDTH-1:0]    i_start_delay,
  input  logic [CNT_WIDTH-1:0]    i_row_words,
  output logic                    o_vs,
  output logic                    o_hs,
  output logic [8*LANE_WIDTH-1:0] o_data,
  output logic                    o_data_valid,
  output logic [31:0]             o_frame_count,
  output logic                    o_busy
);
  localparam logic [CNT_WIDTH-1:0] One      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SyncLast = CNT_WIDTH'(SYNC_LEN - 1);

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, row_q, row_d;
  logic [CNT_WIDTH-1:0]    vblank_q, vblank_d, rows_q, rows_d, hblank_q, hblank_d;
  logic [CNT_WIDTH-1:0]    delay_q, delay_d, words_q, words_d;
  logic [31:0]             frameCnt_q, frameCnt_d;
  logic                    vs_q, vs_d, hs_q, hs_d, valid_q, valid_d, busy_q, busy_d;
  logic [8*LANE_WIDTH-1:0] data_q, data_d, laneData;
  logic [31:0]             syncWord;
  logic                    startFrame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ZERO;
      cnt_q      <= '0;
      row_q      <= '0;
      vblank_q   <= '0;
      rows_q     <= '0;
      hblank_q   <= '0;
      delay_q    <= '0;
      words_q    <= '0;
      frameCnt_q <= '0;
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      vblank_q   <= vblank_d;
      rows_q     <= rows_d;
      hblank_q   <= hblank_d;
      delay_q    <= delay_d;
      words_q    <= words_d;
      frameCnt_q <= frameCnt_d;
      vs_q       <= vs_d;
      hs_q       <= hs_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
    end
  end

  // Config is captured only at frame start, so mid-frame changes wait for the next frame.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    vblank_d   = vblank_q;
    rows_d     = rows_q;
    hblank_d   = hblank_q;
    delay_d    = delay_q;
    words_d    = words_q;
    frameCnt_d = frameCnt_q;
    startFrame = 1'b0;
    case (state_q)
      ST_IDLE: startFrame = i_enable;
      ST_VBLANK:
        if (cnt_q == vblank_q - One) begin
          state_d = row_entry(hblank_q != '0, delay_q != '0);
          cnt_d   = '0;
        end else cnt_d = cnt_q + One;
      ST_HBLANK:
        if (cnt_q == hblank_q - One) begin
          state_d = row_entry(1'b0, delay_q != '0);
          cnt_d   = '0;
        end else cnt_d = cnt_q + One;
      ST_DELAY:
        if (cnt_q == delay_q - One) begin
          state_d = ST_SYNC;
          cnt_d   = '0;
        end else cnt_d = cnt_q + One;
      ST_SYNC:
        if (cnt_q == SyncLast) begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + One;
      ST_PAYLOAD:
        if (cnt_q == words_q - One) begin
          cnt_d = '0;
          if (row_q + One == rows_q) begin
            row_d      = '0;
            frameCnt_d = frameCnt_q + 32'd1;
            if (i_enable) startFrame = 1'b1;
            else          state_d    = ST_IDLE;
          end else begin
            row_d   = row_q + One;
            state_d = row_entry(hblank_q != '0, delay_q != '0);
          end
        end else cnt_d = cnt_q + One;
      default: state_d = ST_IDLE;
    endcase
    if (startFrame) begin
      mode_d   = mode_e'(i_mode);
      vblank_d = i_vblank;
      rows_d   = (i_rows == '0) ? One : i_rows;
      hblank_d = i_hblank;
      delay_d  = i_start_delay;
      words_d  = (i_row_words == '0) ? One : i_row_words;
      cnt_d    = '0;
      row_d    = '0;
      state_d  = (i_vblank != '0) ? ST_VBLANK
                                  : row_entry(i_hblank != '0, i_start_delay != '0);
    end
  end

  for (genvar n = 0; n < LANE_WIDTH; n++) begin : gLane
    imx_lane_pattern #(.LANE_IDX(n)) uLane (
      .mode_i (mode_d),
      .word_i (cnt_d[7:0]),
      .byte_o (laneData[8*n +: 8])
    );
  end

  // Outputs are decoded from the next state so the registered outputs line up with state_q.
  always_comb begin
    vs_d     = 1'b0;
    hs_d     = 1'b0;
    valid_d  = 1'b0;
    data_d   = '0;
    busy_d   = (state_d != ST_IDLE);
    syncWord = SYNC_CODE << {cnt_d[1:0], 3'b000};
    case (state_d)
      ST_HBLANK: vs_d = 1'b1;
      ST_DELAY: begin
        vs_d = 1'b1;
        hs_d = 1'b1;
      end
      ST_SYNC: begin
        vs_d    = 1'b1;
        hs_d    = 1'b1;
        valid_d = 1'b1;
        data_d  = {LANE_WIDTH{syncWord[31:24]}};
      end
      ST_PAYLOAD: begin
        vs_d    = 1'b1;
        hs_d    = 1'b1;
        valid_d = 1'b1;
        data_d  = laneData;
      end
      default: ;
    endcase
  end

  assign o_vs          = vs_q;
  assign o_hs          = hs_q;
  assign o_data        = data_q;
  assign o_data_valid  = valid_q;
  assign o_frame_count = frameCnt_q;
  assign o_busy        = busy_q;
endmodule

// File: tb/tb_imx_frame_pattern_gen.sv
// Bench for imx_frame_pattern_gen: a frame-level expected-output queue checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_imx_frame_pattern_gen;
  import imx_pattern_pkg::*;

  localparam int LW    = 4;
  localparam int CW    = 16;
  localparam int LIMIT = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imx_frame_pattern_gen_if #(.LANE_WIDTH(LW), .CNT_WIDTH(CW)) vif ();

  imx_frame_pattern_gen #(.LANE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (vif.enable),
    .i_mode        (vif.mode),
    .i_vblank      (vif.vblank),
    .i_rows        (vif.rows),
    .i_hblank      (vif.hblank),
    .i_start_delay (vif.start_delay),
    .i_row_words   (vif.row_words),
    .o_vs          (vif.vs),
    .o_hs          (vif.hs),
    .o_data        (vif.data),
    .o_data_valid  (vif.data_valid),
    .o_frame_count (vif.frame_count),
    .o_busy        (vif.busy)
  );

  typedef struct packed {
    logic          vs;
    logic          hs;
    logic          valid;
    logic          busy;
    logic [8*LW-1:0] data;
    logic [31:0]   count;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   modelCount = 0;
  bit   frameOpen  = 1'b0;
  logic [7:0] syncBytes [4] = '{8'h7F, 8'h80, 8'h00, 8'h40};

  function automatic logic [7:0] expByte(int mode, int k, int n);
    case (mode)
      0:       return 8'h00;
      1:       return 8'((k + n) % 256);
      2:       return 8'(n);
      default: return 8'(1 << ((k + n) % 8));
    endcase
  endfunction

  task automatic pushItem(input logic vs, input logic hs, input logic valid,
                          input logic busy, input logic [8*LW-1:0] data);
    exp_t e;
    e.vs = vs; e.hs = hs; e.valid = valid; e.busy = busy;
    e.data = data; e.count = 32'(modelCount);
    expQ.push_back(e);
  endtask

  // Whole frame laid out from the config seen at its start.
  task automatic pushFrame();
    int vb, rw, hb, dl, wd, md;
    logic [8*LW-1:0] d;
    vb = int'(vif.vblank);
    rw = (vif.rows == 0) ? 1 : int'(vif.rows);
    hb = int'(vif.hblank);
    dl = int'(vif.start_delay);
    wd = (vif.row_words == 0) ? 1 : int'(vif.row_words);
    md = int'(vif.mode);
    repeat (vb) pushItem(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int r = 0; r < rw; r++) begin
      repeat (hb) pushItem(1'b1, 1'b0, 1'b0, 1'b1, '0);
      repeat (dl) pushItem(1'b1, 1'b1, 1'b0, 1'b1, '0);
      for (int s = 0; s < 4; s++) begin
        for (int n = 0; n < LW; n++) d[8*n +: 8] = syncBytes[s];
        pushItem(1'b1, 1'b1, 1'b1, 1'b1, d);
      end
      for (int k = 0; k < wd; k++) begin
        for (int n = 0; n < LW; n++) d[8*n +: 8] = expByte(md, k, n);
        pushItem(1'b1, 1'b1, 1'b1, 1'b1, d);
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      expQ.delete();
      modelCount = 0;
      frameOpen  = 1'b0;
      pushItem(1'b0, 1'b0, 1'b0, 1'b0, '0);
    end else if (expQ.size() == 0) begin
      if (frameOpen) begin
        modelCount++;
        frameOpen = 1'b0;
      end
      if (vif.enable) begin
        pushFrame();
        frameOpen = 1'b1;
      end else pushItem(1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      got.vs = vif.vs; got.hs = vif.hs; got.valid = vif.data_valid; got.busy = vif.busy;
      got.data = vif.data; got.count = vif.frame_count;
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("[TB] FAIL model t=%0t vs/hs/valid/busy got %b%b%b%b want %b%b%b%b data got %h want %h count got %0d want %0d",
                 $time, got.vs, got.hs, got.valid, got.busy, e.vs, e.hs, e.valid, e.busy,
                 got.data, e.data, got.count, e.count);
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] md, input int vb, input int rw,
                               input int hb, input int dl, input int wd);
    vif.enable      = en;
    vif.mode        = md;
    vif.vblank      = CW'(vb);
    vif.rows        = CW'(rw);
    vif.hblank      = CW'(hb);
    vif.start_delay = CW'(dl);
    vif.row_words   = CW'(wd);
  endtask

  task automatic waitFor(input string name, input int which);
    int guard = 0;
    while (guard < LIMIT &&
           !((which == 0 && vif.vs === 1'b0) || (which == 1 && vif.data_valid === 1'b1) ||
             (which == 2 && vif.busy === 1'b0) || (which == 3 && vif.busy === 1'b1) ||
             (which == 4 && vif.data_valid === 1'b1 && vif.data[7:0] === 8'h7F))) begin
      @(negedge clk);
      guard++;
    end
    checkOutput(name, longint'(guard < LIMIT), 1);
  endtask

  // Watches one VS-high frame; optionally drops enable at the dropAt-th HS pulse.
  task automatic watchFrame(input int dropAt, output int pulses, output int hsLen, output int validLen);
    int guard = 0;
    logic prevHs = 1'b0;
    pulses = 0; hsLen = 0; validLen = 0;
    while (vif.vs !== 1'b1 && guard < LIMIT) begin @(negedge clk); guard++; end
    while (vif.vs === 1'b1 && guard < LIMIT) begin
      if (vif.hs && !prevHs) begin
        pulses++;
        if (pulses == dropAt) vif.enable = 1'b0;
      end
      if (pulses == 1 && vif.hs) hsLen++;
      if (pulses == 1 && vif.data_valid) validLen++;
      prevHs = vif.hs;
      @(negedge clk);
      guard++;
    end
    checkOutput("frameBound", longint'(guard < LIMIT), 1);
  endtask

  initial begin
    int pulses, hsLen, validLen;
    logic [7:0] cap [300];
    logic [7:0] zeroFrame [5] = '{8'h7F, 8'h80, 8'h00, 8'h40, 8'h00};
    logic [31:0] c0;

    applyStimulus(1'b0, 2'd0, 10, 10, 10, 10, 100);
    repeat (3) @(negedge clk);
    checkOutput("resetCount", vif.frame_count, 0);
    checkOutput("resetVs", vif.vs, 0);
    checkOutput("resetBusy", vif.busy, 0);
    checkOutput("resetData", vif.data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] default frame, mode 0");
    vif.enable = 1'b1;
    watchFrame(0, pulses, hsLen, validLen);
    checkOutput("defPulses", pulses, 10);
    checkOutput("defHsLen", hsLen, 114);
    checkOutput("defValidLen", validLen, 104);
    checkOutput("defCount", vif.frame_count, 1);

    $display("[TB] mid-frame config change");
    vif.row_words = CW'(50);
    vif.mode      = 2'd3;
    watchFrame(0, pulses, hsLen, validLen);
    checkOutput("oldWords", validLen, 104);
    checkOutput("frame2Count", vif.frame_count, 2);

    $display("[TB] enable dropped in row 3");
    watchFrame(3, pulses, hsLen, validLen);
    checkOutput("dropPulses", pulses, 10);
    checkOutput("newWords", validLen, 54);
    checkOutput("dropBusy", vif.busy, 0);
    checkOutput("dropCount", vif.frame_count, 3);

    $display("[TB] mode 1 wrap on lane 2");
    applyStimulus(1'b1, 2'd1, 2, 2, 3, 1, 300);
    waitFor("syncWait", 1);
    checkOutput("lane2Sync0", vif.data[23:16], 8'h7F);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      cap[k] = vif.data[23:16];
      @(negedge clk);
    end
    vif.enable = 1'b0;
    checkOutput("lane2W0", cap[0], 8'h02);
    checkOutput("lane2W1", cap[1], 8'h03);
    checkOutput("lane2W253", cap[253], 8'hFF);
    checkOutput("lane2W254", cap[254], 8'h00);
    checkOutput("lane2W255", cap[255], 8'h01);
    checkOutput("lane2W299", cap[299], 8'h2D);
    waitFor("idleWait", 2);
    checkOutput("mode1Count", vif.frame_count, 4);

    $display("[TB] all-zero config");
    applyStimulus(1'b1, 2'd0, 0, 0, 0, 0, 0);
    waitFor("zeroSync", 4);
    for (int i = 0; i < 5; i++) begin
      checkOutput("zeroLane0", vif.data[7:0], zeroFrame[i]);
      checkOutput("zeroHs", vif.hs, 1);
      @(negedge clk);
    end
    c0 = vif.frame_count;
    repeat (25) @(negedge clk);
    checkOutput("zeroRate", vif.frame_count - c0, 5);

    $display("[TB] reset during payload");
    applyStimulus(1'b1, 2'd2, 10, 10, 10, 10, 100);
    waitFor("vblankWait", 0);
    waitFor("rowWait", 1);
    repeat (6) @(negedge clk);
    checkOutput("laneIdx1", vif.data[15:8], 8'h01);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstVs", vif.vs, 0);
    checkOutput("rstHs", vif.hs, 0);
    checkOutput("rstValid", vif.data_valid, 0);
    checkOutput("rstData", vif.data, 0);
    checkOutput("rstCount", vif.frame_count, 0);
    checkOutput("rstBusy", vif.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("restartBusy", vif.busy, 1);
    checkOutput("restartVs", vif.vs, 0);
    repeat (300) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/imx_frame_pattern_gen.md
IMX_FRAME_PATTERN_GEN -- requirements
Module: imx_frame_pattern_gen

Interface
REQ-001 SHALL have parameter LANE_WIDTH, default 8, number of 8-bit data lanes.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of all timing config inputs.
REQ-003 SHALL have parameter SYNC_CODE, default 32'h7F80_0040, four row-start sync bytes, MSB byte first.
REQ-004 SHALL have port clk, input, 1, the only clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_enable, input, 1, run frames while high.
REQ-007 SHALL have port i_mode, input, 2, payload mode: 0 zero, 1 incrementing, 2 lane index, 3 walking-one.
REQ-008 SHALL have port i_vblank, input, CNT_WIDTH, VS-low cycles between frames.
REQ-009 SHALL have port i_rows, input, CNT_WIDTH, HS pulses per frame.
REQ-010 SHALL have port i_hblank, input, CNT_WIDTH, HS-low cycles before each row.
REQ-011 SHALL have port i_start_delay, input, CNT_WIDTH, HS-high idle cycles before sync code.
REQ-012 SHALL have port i_row_words, input, CNT_WIDTH, payload words per row.
REQ-013 SHALL have port o_vs, output, 1, vertical sync.
REQ-014 SHALL have port o_hs, output, 1, horizontal sync.
REQ-015 SHALL have port o_data, output, 8*LANE_WIDTH, lane n at bits [8n+7:8n].
REQ-016 SHALL have port o_data_valid, output, 1, high on sync and payload words.
REQ-017 SHALL have port o_frame_count, output, 32, completed frames, wraps at 2^32.
REQ-018 SHALL have port o_busy, output, 1, high whenever state is not IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, VBLANK, HBLANK, DELAY, SYNC, PAYLOAD; all outputs registered.
REQ-020 SHALL go IDLE->VBLANK the cycle after i_enable is sampled high, latching all config inputs and i_mode.
REQ-021 SHALL hold o_vs=0, o_hs=0 for exactly i_vblank cycles in VBLANK, then enter HBLANK with o_vs=1.
REQ-022 SHALL hold o_hs=0 for i_hblank cycles in HBLANK, then o_hs=1 for DELAY (i_start_delay cycles, o_data=0, valid=0).
REQ-023 SHALL emit SYNC as 4 cycles, each lane carrying the same SYNC_CODE byte in order 7F,80,00,40, valid=1.
REQ-024 SHALL emit PAYLOAD for i_row_words cycles, valid=1; lane n word k: mode0 0, mode1 (k+n) mod 256, mode2 n, mode3 8'h01<<((k+n) mod 8).
REQ-025 SHALL drop o_hs on the cycle after the last payload word; row counter increments then.
REQ-026 SHALL, after row i_rows completes, drop o_vs, increment o_frame_count, and enter VBLANK if i_enable high else IDLE.
REQ-027 SHALL treat zero values of i_vblank, i_hblank, i_start_delay as skip-state (zero cycles); i_rows=0 or i_row_words=0 SHALL be clamped to 1.
REQ-028 SHALL ignore config changes mid-frame; new values take effect at next VBLANK entry.
REQ-029 SHALL finish the current frame when i_enable falls mid-frame; no truncated rows or frames.
REQ-030 SHALL keep o_data=0 and o_data_valid=0 outside SYNC and PAYLOAD.

Reset
REQ-031 SHALL on rst (synchronous, active-high, priority over all) force IDLE, o_vs=0, o_hs=0, o_data=0, o_data_valid=0, o_frame_count=0, o_busy=0, all counters 0.
REQ-032 SHALL abort any frame on reset mid-operation; no frame count increment for it.

Structure
REQ-033 SHALL place FSM state encoding, mode encodings and SYNC length (4) in shared package imx_pattern_pkg.
REQ-034 SHALL use one sub-module imx_lane_pattern (per-lane payload byte from mode, word index, lane index), instantiated LANE_WIDTH times via generate.

Verification
REQ-035 Defaults, vblank=10, rows=10, hblank=10, delay=10, words=100, mode0 -> 10 HS pulses per VS, each HS high 114 cycles, lanes 7F,80,00,40 then 100 zeros.
REQ-036 Mode1, LANE_WIDTH=4, words=300 -> lane 2 payload 02,03,...,FF,00,01..., wraps at 256.
REQ-037 Config vblank=0, hblank=0, delay=0, rows=0, words=0 -> 1 row, 4 sync + 1 payload word, o_hs high 5 cycles, frame count increments each 5-cycle frame.
REQ-038 i_enable low during row 3 of 10 -> frame completes all 10 rows, o_frame_count +1, o_busy falls, IDLE.
REQ-039 rst asserted during PAYLOAD -> next cycle all outputs 0, o_frame_count 0; re-enable restarts at VBLANK.
REQ-040 i_row_words changed 100->50 mid-frame -> current frame rows stay 100 words, next frame rows 50 words.
